syn_down_counter: RTL and testbench



---
 rtl/syn_down_counter.sv | 112 +++++++++++
 tb/tb_syn_down_counter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/syn_down_counter.sv
// ---------------------------------------------------------------------------
// syn_down_counter
//
// Synchronous binary down counter, WIDTH bits wide (legal range 2..16).
// The count register is a bank of per-bit D flip-flops. The decrement is
// dataflow: each bit toggles when a borrow ripples in, meaning en is high and
// every lower bit is 0. The counter also provides a parallel load, a zero
// flag and a cascadable borrow output.
//
// Next-state priority per rising edge: reset, then load, then decrement,
// then hold.
//
// Optional feature (macro SYN_DOWN_COUNTER_RELOAD_EN):
//   A reload register captures din on every load. When the count is 0 and
//   en is high, the count wraps to the reload value instead of all ones.
//   This gives a periodic divide-by-(din+1) timer. Before the first load the
//   reload register holds all ones, so behaviour matches the default build.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-low
//   en     in   count enable (decrement by one per edge)
//   load   in   parallel load strobe; takes priority over en
//   din    in   WIDTH-bit load value
//   out    out  WIDTH-bit registered count
//   zero   out  out == 0 (combinational)
//   borrow out  en & zero (combinational); feeds en of the next-higher stage
// ---------------------------------------------------------------------------
module syn_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             borrow
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH:0]   borrow_chain;

    // borrow_chain[i] is high when bit i must toggle. That happens when en is
    // high and bits 0..i-1 are all zero. When the count is 0 every bit
    // toggles, which produces the natural wrap to all ones.
    always_comb begin
        borrow_chain[0] = en;
        dec_val         = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_val[i]        = count_q[i] ^ borrow_chain[i];
            borrow_chain[i+1] = borrow_chain[i] & ~count_q[i];
        end
    end

`ifdef SYN_DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;

    always_comb begin
        reload_d = reload_q;
        if (load) begin
            reload_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reload_q <= '1;
        end else begin
            reload_q <= reload_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = din;
        end else if (en && zero) begin
            count_d = reload_q;
        end else if (en) begin
            count_d = dec_val;
        end
    end
`else
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = din;
        end else if (en) begin
            count_d = dec_val;
        end
    end
`endif

    // Reset overrides load and en in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '1;
        end else begin
            count_q <= count_d;
        end
    end

    assign out    = count_q;
    assign zero   = ~|count_q;
    assign borrow = en & zero;

endmodule

// File: tb/tb_syn_down_counter.sv
module tb_syn_down_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, load;
    logic [3:0] din;
    logic [3:0] out;
    logic       zero, borrow;

    logic       rst_c, en_c;
    logic       load_c;
    logic [3:0] din_c;
    logic [3:0] lo_out, hi_out;
    logic       lo_zero, lo_borrow, hi_zero, hi_borrow;

    int errors = 0;
    int checks = 0;
    int m;
    int rl;
    int c16;

    syn_down_counter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
        .out(out), .zero(zero), .borrow(borrow)
    );

    syn_down_counter #(.WIDTH(4)) u_lo (
        .clk(clk), .rst(rst_c), .en(en_c), .load(load_c), .din(din_c),
        .out(lo_out), .zero(lo_zero), .borrow(lo_borrow)
    );

    syn_down_counter #(.WIDTH(4)) u_hi (
        .clk(clk), .rst(rst_c), .en(lo_borrow), .load(load_c), .din(din_c),
        .out(hi_out), .zero(hi_zero), .borrow(hi_borrow)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies one set of inputs across one rising edge, advances the
    // reference model, and checks out, zero and borrow just after the edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic l, input logic [3:0] d);
        rst  = r;
        en   = e;
        load = l;
        din  = d;
        @(posedge clk);
        if (!r) begin
            m  = 15;
            rl = 15;
        end else if (l) begin
            m  = d;
            rl = d;
        end else if (e) begin
            if (m == 0) begin
`ifdef SYN_DOWN_COUNTER_RELOAD_EN
                m = rl;
`else
                m = 15;
`endif
            end else begin
                m = m - 1;
            end
        end
        #1;
        chk({tag, "_out"},    16'(out),    16'(m));
        chk({tag, "_zero"},   16'(zero),   16'(m == 0));
        chk({tag, "_borrow"}, 16'(borrow), 16'(e && (m == 0)));
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; load = 1'b1; din = 4'h7;
        rst_c = 1'b0; en_c = 1'b0; load_c = 1'b0; din_c = 4'h0;
        m = 15; rl = 15;

        // Reset dominates en and load.
        step("reset0", 1'b0, 1'b1, 1'b1, 4'h7);
        step("reset1", 1'b0, 1'b1, 1'b1, 4'h7);
        chk("reset_const", 16'(out), 16'hF);

        // Free-run through the wrap.
        for (int i = 0; i < 17; i++) step("freerun", 1'b1, 1'b1, 1'b0, 4'h0);
        chk("freerun_end", 16'(out), 16'hE);

        // Load and hold, then load wins over en.
        step("load5", 1'b1, 1'b0, 1'b1, 4'h5);
        for (int i = 0; i < 3; i++) step("hold", 1'b1, 1'b0, 1'b0, 4'hA);
        step("load_vs_en", 1'b1, 1'b1, 1'b1, 4'h9);
        chk("load_vs_en_const", 16'(out), 16'h9);

        // Mid-operation reset.
        step("load8", 1'b1, 1'b0, 1'b1, 4'h8);
        step("dec7", 1'b1, 1'b1, 1'b0, 4'h0);
        step("dec6", 1'b1, 1'b1, 1'b0, 4'h0);
        step("midrst", 1'b0, 1'b1, 1'b0, 4'h0);
        chk("midrst_const", 16'(out), 16'hF);
        step("rst_release", 1'b1, 1'b1, 1'b0, 4'h0);
        chk("rst_release_const", 16'(out), 16'hE);

        // Load of zero with en low: zero set, borrow low until en rises.
        step("load0", 1'b1, 1'b0, 1'b1, 4'h0);
        step("idle0", 1'b1, 1'b0, 1'b0, 4'h0);
        en = 1'b1;
        #1;
        chk("borrow_on_en_rise", 16'(borrow), 16'h1);
        step("wrap_from0", 1'b1, 1'b1, 1'b0, 4'h0);

        // Periodic reload (or plain wrap in the default build).
        step("load3", 1'b1, 1'b0, 1'b1, 4'h3);
        for (int i = 0; i < 5; i++) step("period", 1'b1, 1'b1, 1'b0, 4'h0);
`ifdef SYN_DOWN_COUNTER_RELOAD_EN
        chk("period_end", 16'(out), 16'h2);
`else
        chk("period_end", 16'(out), 16'hE);
`endif

        // Random stimulus against the model.
        for (int i = 0; i < 300; i++) begin
            step("rand",
                 logic'($urandom_range(0, 19) != 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 7) == 0),
                 4'($urandom));
        end

        // Two-stage cascade behaves as one 8-bit down counter.
        rst_c = 1'b0;
        en_c  = 1'b1;
        @(posedge clk);
        #1;
        c16 = 255;
        chk("casc_reset", {8'h0, hi_out, lo_out}, 16'(c16));
        rst_c = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk);
            #1;
            c16 = (c16 + 255) % 256;
            chk("casc_step", {8'h0, hi_out, lo_out}, 16'(c16));
            if (i == 16)  chk("casc_16",  {8'h0, hi_out, lo_out}, 16'h00EF);
            if (i == 256) chk("casc_256", {8'h0, hi_out, lo_out}, 16'h00FF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
